// File: rtl/com_slink_rx_chk_if.sv
// SLINK receive byte stream plus the per-packet check results handed to the diagnose stage.
interface com_slink_rx_chk_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_sop;
  logic       rx_eop;
  logic       chn_pkt_eop;
  logic       chn_pkt_len_err;
  logic       chn_pkt_crc_err;
  logic       chn_pkt_tick_err;
  logic       chn_pkt_delay_err;
  logic       chn_break_err;

  modport master (
    output rx_data, rx_valid, rx_sop, rx_eop,
    input  chn_pkt_eop, chn_pkt_len_err, chn_pkt_crc_err, chn_pkt_tick_err,
           chn_pkt_delay_err, chn_break_err
  );

  modport slave (
    input  rx_data, rx_valid, rx_sop, rx_eop,
    output chn_pkt_eop, chn_pkt_len_err, chn_pkt_crc_err, chn_pkt_tick_err,
           chn_pkt_delay_err, chn_break_err
  );
endinterface

// File: rtl/com_slink_rx_chk.sv
// Per-channel SLINK receive checker: packet length, CRC-16/CCITT-FALSE residue, tick sequence,
// inter-packet delay and link-silence (break) detection.
//
// state  | meaning
// S_IDLE | waiting for a start-of-packet byte
// S_RECV | inside a packet, accumulating length and CRC
module com_slink_rx_chk #(
  parameter logic [11:0] PKT_LEN       = 12'd32,
  parameter logic [19:0] BREAK_TIMEOUT = 20'd125000,
  parameter logic [19:0] DELAY_TIMEOUT = 20'd62500
) (
  input  logic               clk_12_5m,
  input  logic               rst_12_5m,
  input  logic               chn_enable,
  com_slink_rx_chk_if.slave  rx
);

  typedef enum logic {S_IDLE, S_RECV} state_t;

  state_t      state_q, state_d;
  logic [11:0] byte_cnt_q, byte_cnt_d;
  logic [15:0] crc_q, crc_d;
  logic [7:0]  rx_tick_q, rx_tick_d;
  logic [7:0]  exp_tick_q;
  logic        tick_ref_vld_q;
  logic [19:0] idle_cnt_q;
  logic [19:0] gap_cnt_q;
  logic        gap_armed_q;
  logic        close;
  logic        len_bad, crc_bad, pkt_good, tick_bad;
  logic [11:0] cnt_inc;
  logic [15:0] crc_seed, crc_next;

  logic pkt_eop_q, len_err_q, crc_err_q, tick_err_q, delay_err_q, break_err_q;

  function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  always_ff @(posedge clk_12_5m) begin
    if (rst_12_5m || !chn_enable) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    crc_d      = crc_q;
    rx_tick_d  = rx_tick_q;
    close      = 1'b0;
    cnt_inc    = (byte_cnt_q == 12'hFFF) ? byte_cnt_q : byte_cnt_q + 12'd1;
    crc_seed   = crc16_upd(16'hFFFF, rx.rx_data);
    crc_next   = crc16_upd(crc_q, rx.rx_data);
    case (state_q)
      S_IDLE: begin
        if (rx.rx_valid && rx.rx_sop) begin
          byte_cnt_d = 12'd1;
          crc_d      = crc_seed;
          if (rx.rx_eop) close = 1'b1;
          else           state_d = S_RECV;
        end
      end
      S_RECV: begin
        if (rx.rx_valid) begin
          // A fresh sop abandons the packet in flight silently.
          if (rx.rx_sop && !rx.rx_eop) begin
            byte_cnt_d = 12'd1;
            crc_d      = crc_seed;
          end else begin
            byte_cnt_d = cnt_inc;
            crc_d      = crc_next;
            if (byte_cnt_q == 12'd1) rx_tick_d = rx.rx_data;
            if (rx.rx_eop) begin
              close   = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    len_bad  = (byte_cnt_d != PKT_LEN);
    crc_bad  = (crc_d != 16'h0000);
    pkt_good = !len_bad && !crc_bad;
    tick_bad = tick_ref_vld_q && pkt_good && (rx_tick_d != exp_tick_q);
  end

  always_ff @(posedge clk_12_5m) begin
    if (rst_12_5m || !chn_enable) begin
      byte_cnt_q     <= 12'd0;
      crc_q          <= 16'hFFFF;
      rx_tick_q      <= 8'd0;
      exp_tick_q     <= 8'd0;
      tick_ref_vld_q <= 1'b0;
      idle_cnt_q     <= 20'd0;
      gap_cnt_q      <= 20'd0;
      gap_armed_q    <= 1'b0;
      pkt_eop_q      <= 1'b0;
      len_err_q      <= 1'b0;
      crc_err_q      <= 1'b0;
      tick_err_q     <= 1'b0;
      delay_err_q    <= 1'b0;
      break_err_q    <= 1'b0;
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      crc_q       <= crc_d;
      rx_tick_q   <= rx_tick_d;
      pkt_eop_q   <= close;
      delay_err_q <= 1'b0;

      if (rx.rx_valid)                       idle_cnt_q <= 20'd0;
      else if (idle_cnt_q != BREAK_TIMEOUT)  idle_cnt_q <= idle_cnt_q + 20'd1;

      if (idle_cnt_q == BREAK_TIMEOUT) begin
        break_err_q    <= 1'b1;
        tick_ref_vld_q <= 1'b0;
      end

      // A packet end takes priority over a delay overrun landing in the same cycle.
      if (close) begin
        len_err_q   <= len_bad;
        crc_err_q   <= crc_bad;
        tick_err_q  <= tick_bad;
        gap_armed_q <= 1'b1;
        gap_cnt_q   <= 20'd0;
        if (pkt_good) begin
          exp_tick_q     <= rx_tick_d + 8'd1;
          tick_ref_vld_q <= 1'b1;
          break_err_q    <= 1'b0;
        end
      end else if (gap_armed_q && gap_cnt_q != DELAY_TIMEOUT) begin
        gap_cnt_q <= gap_cnt_q + 20'd1;
        if (gap_cnt_q + 20'd1 == DELAY_TIMEOUT) delay_err_q <= 1'b1;
      end
    end
  end

  assign rx.chn_pkt_eop       = pkt_eop_q;
  assign rx.chn_pkt_len_err   = len_err_q;
  assign rx.chn_pkt_crc_err   = crc_err_q;
  assign rx.chn_pkt_tick_err  = tick_err_q;
  assign rx.chn_pkt_delay_err = delay_err_q;
  assign rx.chn_break_err     = break_err_q;

endmodule

// File: tb/tb_com_slink_rx_chk.sv
// Bench for com_slink_rx_chk: packet table through a strobe scoreboard, plus hand sequences
// for restart, 1-byte packet, disable mid-packet, delay overrun and link break.
module tb_com_slink_rx_chk;
  localparam logic [11:0] PKT_LEN = 12'd32;
  localparam logic [19:0] BRK_TO  = 20'd200;
  localparam logic [19:0] DLY_TO  = 20'd100;

  logic clk_12_5m = 1'b0;
  logic rst_12_5m;
  logic chn_enable;
  always #40 clk_12_5m = ~clk_12_5m;

  com_slink_rx_chk_if rx_if ();

  com_slink_rx_chk #(
    .PKT_LEN(PKT_LEN), .BREAK_TIMEOUT(BRK_TO), .DELAY_TIMEOUT(DLY_TO)
  ) dut (
    .clk_12_5m (clk_12_5m),
    .rst_12_5m (rst_12_5m),
    .chn_enable(chn_enable),
    .rx        (rx_if)
  );

  int cyc = 0;
  always @(posedge clk_12_5m) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { int cyc; bit len_e; bit crc_e; bit tick_e; } exp_t;
  exp_t sb[$];

  typedef struct { int len; logic [7:0] tick; int corrupt; bit len_e; bit crc_e; bit tick_e; } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bit-serial reference CRC-16/CCITT-FALSE step.
  function automatic logic [15:0] ref_crc(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    logic fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  always @(negedge clk_12_5m) begin : mon
    exp_t e;
    if (sb.size() > 0 && cyc > sb[0].cyc) begin
      n_cmp++; n_bad++;
      $display("FAIL eop_missing: no strobe by cycle %0d, expected at %0d", cyc, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (rx_if.chn_pkt_eop === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL eop_unexpected: strobe at cycle %0d, expected none", cyc);
      end else begin
        e = sb.pop_front();
        chk("eop_cycle", cyc, e.cyc);
        chk("len_err",  {31'd0, rx_if.chn_pkt_len_err},  {31'd0, e.len_e});
        chk("crc_err",  {31'd0, rx_if.chn_pkt_crc_err},  {31'd0, e.crc_e});
        chk("tick_err", {31'd0, rx_if.chn_pkt_tick_err}, {31'd0, e.tick_e});
      end
    end
  end

  task automatic go_idle();
    rx_if.rx_valid = 1'b0;
    rx_if.rx_sop   = 1'b0;
    rx_if.rx_eop   = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit sop, input bit eop);
    rx_if.rx_data  = d;
    rx_if.rx_valid = 1'b1;
    rx_if.rx_sop   = sop;
    rx_if.rx_eop   = eop;
    @(posedge clk_12_5m);
    #1;
  endtask

  task automatic send_pkt(input int len, input logic [7:0] tick, input int corrupt,
                          input bit le, input bit ce, input bit te);
    logic [7:0] b [0:63];
    logic [15:0] crc;
    exp_t e;
    b[0] = 8'hA5;
    b[1] = tick;
    for (int i = 2; i < len - 2; i++) b[i] = 8'(i * 3) + tick;
    crc = 16'hFFFF;
    for (int i = 0; i < len - 2; i++) crc = ref_crc(crc, b[i]);
    b[len-2] = crc[15:8];
    b[len-1] = crc[7:0];
    if (corrupt >= 0) b[corrupt] = b[corrupt] ^ 8'h5A;
    for (int i = 0; i < len; i++) begin
      if (i == len - 1) begin
        e.cyc = cyc + 1; e.len_e = le; e.crc_e = ce; e.tick_e = te;
        sb.push_back(e);
      end
      send_byte(b[i], i == 0, i == len - 1);
    end
  endtask

  task automatic send_partial(input int n);
    for (int i = 0; i < n; i++) send_byte(8'hC0 + 8'(i), i == 0, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_eop"},   {31'd0, rx_if.chn_pkt_eop},       32'd0);
    chk({tag, "_len"},   {31'd0, rx_if.chn_pkt_len_err},   32'd0);
    chk({tag, "_crc"},   {31'd0, rx_if.chn_pkt_crc_err},   32'd0);
    chk({tag, "_tick"},  {31'd0, rx_if.chn_pkt_tick_err},  32'd0);
    chk({tag, "_delay"}, {31'd0, rx_if.chn_pkt_delay_err}, 32'd0);
    chk({tag, "_break"}, {31'd0, rx_if.chn_break_err},     32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin : main
    exp_t e;
    int pulses;
    int pulse_k;
    int brk_k;

    vecs = '{
      '{32, 8'h10, -1, 1'b0, 1'b0, 1'b0},
      '{32, 8'h11, -1, 1'b0, 1'b0, 1'b0},
      '{32, 8'h12, -1, 1'b0, 1'b0, 1'b0},
      '{32, 8'h13, -1, 1'b0, 1'b0, 1'b0},
      '{31, 8'h14, -1, 1'b1, 1'b0, 1'b0},
      '{33, 8'h77, -1, 1'b1, 1'b0, 1'b0},
      '{32, 8'h14,  5, 1'b0, 1'b1, 1'b0},
      '{32, 8'h14, -1, 1'b0, 1'b0, 1'b0},
      '{32, 8'hFE, -1, 1'b0, 1'b0, 1'b1},
      '{32, 8'hFF, -1, 1'b0, 1'b0, 1'b0},
      '{32, 8'h00, -1, 1'b0, 1'b0, 1'b0},
      '{32, 8'h02, -1, 1'b0, 1'b0, 1'b1}
    };

    rst_12_5m     = 1'b1;
    chn_enable    = 1'b1;
    rx_if.rx_data = 8'h00;
    go_idle();
    repeat (3) @(posedge clk_12_5m);
    @(negedge clk_12_5m);
    chk_all_zero("reset");
    @(posedge clk_12_5m);
    #1;
    rst_12_5m = 1'b0;
    repeat (2) @(posedge clk_12_5m);
    #1;

    // Back-to-back table packets.
    for (int i = 0; i < 12; i++)
      send_pkt(vecs[i].len, vecs[i].tick, vecs[i].corrupt,
               vecs[i].len_e, vecs[i].crc_e, vecs[i].tick_e);
    go_idle();
    repeat (3) @(posedge clk_12_5m);
    #1;

    // sop mid-packet restarts; only the second packet strobes.
    send_partial(10);
    send_pkt(32, 8'h03, -1, 1'b0, 1'b0, 1'b0);
    go_idle();
    repeat (3) @(posedge clk_12_5m);
    #1;

    // Single-byte packet, then disable in the middle of the following packet.
    e.cyc = cyc + 1; e.len_e = 1'b1; e.crc_e = (ref_crc(16'hFFFF, 8'h3C) != 16'h0000); e.tick_e = 1'b0;
    sb.push_back(e);
    send_byte(8'h3C, 1'b1, 1'b1);
    send_partial(10);
    @(negedge clk_12_5m);
    chk("len_err_held", {31'd0, rx_if.chn_pkt_len_err}, 32'd1);
    @(posedge clk_12_5m);
    #1;
    chn_enable = 1'b0;
    go_idle();
    @(posedge clk_12_5m);
    @(negedge clk_12_5m);
    chk_all_zero("disable");
    @(posedge clk_12_5m);
    #1;
    chn_enable = 1'b1;
    repeat (2) @(posedge clk_12_5m);
    #1;

    // Tick reference was dropped by the disable, so an arbitrary tick is accepted.
    send_pkt(32, 8'h50, -1, 1'b0, 1'b0, 1'b0);
    go_idle();

    // Silence: one delay pulse, then break.
    pulses = 0; pulse_k = -1; brk_k = -1;
    for (int k = 1; k <= 210; k++) begin
      @(posedge clk_12_5m);
      @(negedge clk_12_5m);
      if (rx_if.chn_pkt_delay_err === 1'b1) begin
        pulses++;
        pulse_k = k;
      end
      if (rx_if.chn_break_err === 1'b1 && brk_k < 0) brk_k = k;
    end
    chk("delay_pulses", pulses, 32'd1);
    chk("delay_cycle", pulse_k, 32'd100);
    chk("break_cycle", brk_k, 32'd201);
    chk("break_level", {31'd0, rx_if.chn_break_err}, 32'd1);
    @(posedge clk_12_5m);
    #1;

    // Any tick after a break is accepted and clears the break with the strobe.
    send_pkt(32, 8'h99, -1, 1'b0, 1'b0, 1'b0);
    go_idle();
    @(negedge clk_12_5m);
    chk("break_clear_eop", {31'd0, rx_if.chn_pkt_eop}, 32'd1);
    chk("break_clear", {31'd0, rx_if.chn_break_err}, 32'd0);

    repeat (4) @(posedge clk_12_5m);
    @(negedge clk_12_5m);
    chk("sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
